// File: rtl/pgm_wr_ctl_if.sv
// PGM write-stage bus bundle: upstream data/PHV, downstream to pgm_rd, PGM RAM write port, cfg chain.
interface pgm_wr_ctl_if #(
   parameter int unsigned RAM_AW = 7,
   parameter int unsigned RAM_DW = 144
);
   localparam int unsigned PHV_W  = 1024;
   localparam int unsigned FLIT_W = 134;

   // upstream side
   logic [PHV_W-1:0]  in_wr_phv;
   logic              in_wr_phv_wr;
   logic              out_wr_phv_alf;
   logic [FLIT_W-1:0] in_wr_data;
   logic              in_wr_data_wr;
   logic              in_wr_valid;
   logic              in_wr_valid_wr;
   logic              out_wr_alf;
   // downstream (pgm_rd) side
   logic [PHV_W-1:0]  out_wr_phv;
   logic              out_wr_phv_wr;
   logic              in_wr_phv_alf;
   logic [FLIT_W-1:0] out_wr_data;
   logic              out_wr_data_wr;
   logic              out_wr_valid;
   logic              out_wr_valid_wr;
   logic              in_wr_alf;
   // PGM RAM write port and status to pgm_rd
   logic              wr2ram_wr_en;
   logic [RAM_DW-1:0] wr2ram_wdata;
   logic [RAM_AW-1:0] wr2ram_addr;
   logic              pgm_bypass_flag;
   logic              pgm_sent_start_flag;
   logic              pgm_sent_finish_flag;
   // cfg chain
   logic [FLIT_W-1:0] cin_wr_data;
   logic              cin_wr_data_wr;
   logic              cout_wr_ready;
   logic [FLIT_W-1:0] cout_wr_data;
   logic              cout_wr_data_wr;
   logic              cin_wr_ready;

   modport slave (
      input  in_wr_phv, in_wr_phv_wr, in_wr_data, in_wr_data_wr, in_wr_valid, in_wr_valid_wr,
      input  in_wr_phv_alf, in_wr_alf, cin_wr_data, cin_wr_data_wr, cin_wr_ready,
      output out_wr_phv_alf, out_wr_alf, out_wr_phv, out_wr_phv_wr, out_wr_data, out_wr_data_wr,
      output out_wr_valid, out_wr_valid_wr, wr2ram_wr_en, wr2ram_wdata, wr2ram_addr,
      output pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
      output cout_wr_ready, cout_wr_data, cout_wr_data_wr
   );

   modport master (
      output in_wr_phv, in_wr_phv_wr, in_wr_data, in_wr_data_wr, in_wr_valid, in_wr_valid_wr,
      output in_wr_phv_alf, in_wr_alf, cin_wr_data, cin_wr_data_wr, cin_wr_ready,
      input  out_wr_phv_alf, out_wr_alf, out_wr_phv, out_wr_phv_wr, out_wr_data, out_wr_data_wr,
      input  out_wr_valid, out_wr_valid_wr, wr2ram_wr_en, wr2ram_wdata, wr2ram_addr,
      input  pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag,
      input  cout_wr_ready, cout_wr_data, cout_wr_data_wr
   );
endinterface

// File: rtl/pgm_wr_ctl.sv
// PGM write stage: one-cycle data/PHV pipe to pgm_rd, cfg-chain snoop that loads PGM RAM,
// bypass and packet start/finish indications for pgm_rd.
module pgm_wr_ctl #(
   parameter logic [7:0]  MODULE_ID = 8'd70,
   parameter int unsigned RAM_AW    = 7,
   parameter int unsigned RAM_DW    = 144
) (
   input  logic        clk,
   input  logic        rst,
   pgm_wr_ctl_if.slave bus
);
   localparam int unsigned PHV_W     = 1024;
   localparam int unsigned FLIT_W    = 134;
   localparam int unsigned HI_W      = 16;
   localparam int unsigned ADDR_LSB  = 64;
   localparam logic [5:0]  HDR_HEAD  = 6'b010000;
   localparam logic [5:0]  HDR_TAIL  = 6'b100000;
   localparam logic [2:0]  OP_RAM_WR = 3'b001;

   typedef enum logic {ST_IDLE = 1'b0, ST_HEAD = 1'b1} state_t;

   state_t              state_q, state_d;
   logic                match_q, match_d;
   logic [RAM_AW-1:0]   lat_addr_q, lat_addr_d;
   logic [HI_W-1:0]     hi16_q, hi16_d;
   logic                ram_we_q, ram_we_d;
   logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
   logic [RAM_DW-1:0]   ram_wdata_q, ram_wdata_d;
   logic                bypass_q, bypass_d;
   logic [PHV_W-1:0]    phv_q, phv_d;
   logic                phv_wr_q, phv_wr_d;
   logic [FLIT_W-1:0]   data_q, data_d;
   logic                data_wr_q, data_wr_d;
   logic                valid_q, valid_d;
   logic                valid_wr_q, valid_wr_d;
   logic [FLIT_W-1:0]   cout_q, cout_d;
   logic                cout_wr_q, cout_wr_d;
   logic                start_q, start_d;
   logic                finish_q, finish_d;

   logic [5:0]          cin_hdr_c;
   logic [5:0]          data_hdr_c;
   logic                cin_match_c;

   // Header decode and cfg target match
   assign cin_hdr_c   = bus.cin_wr_data[133:128];
   assign data_hdr_c  = bus.in_wr_data[133:128];
   assign cin_match_c = bus.cin_wr_data[127] && (bus.cin_wr_data[126:124] == OP_RAM_WR) &&
                        (bus.cin_wr_data[111:104] == MODULE_ID);

   // Flow-control pass-through (combinational by design)
   assign bus.cout_wr_ready  = bus.cin_wr_ready;
   assign bus.out_wr_alf     = bus.in_wr_alf;
   assign bus.out_wr_phv_alf = bus.in_wr_phv_alf;

   // Cfg FSM next state: track head/tail, latch matched head fields, issue RAM write on tail
   always_comb begin
      state_d     = state_q;
      match_d     = match_q;
      lat_addr_d  = lat_addr_q;
      hi16_d      = hi16_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      bypass_d    = bypass_q;
      if (bus.cin_wr_data_wr) begin
         if (cin_hdr_c == HDR_HEAD) begin
            // a head in either state (re)starts a packet; an earlier head is dropped
            state_d = ST_HEAD;
            match_d = cin_match_c;
            if (cin_match_c) begin
               lat_addr_d = bus.cin_wr_data[ADDR_LSB +: RAM_AW];
               hi16_d     = bus.cin_wr_data[HI_W-1:0];
            end
         end else if ((cin_hdr_c == HDR_TAIL) && (state_q == ST_HEAD)) begin
            state_d = ST_IDLE;
            match_d = 1'b0;
            if (match_q) begin
               ram_we_d    = 1'b1;
               ram_addr_d  = lat_addr_q;
               ram_wdata_d = RAM_DW'({hi16_q, bus.cin_wr_data[127:0]});
               bypass_d    = 1'b0;
            end
         end
      end
   end

   // Data/PHV/cfg pipe next state and packet start/finish indications
   always_comb begin
      phv_d      = bus.in_wr_phv_wr   ? bus.in_wr_phv   : phv_q;
      phv_wr_d   = bus.in_wr_phv_wr;
      data_d     = bus.in_wr_data_wr  ? bus.in_wr_data  : data_q;
      data_wr_d  = bus.in_wr_data_wr;
      valid_d    = bus.in_wr_valid_wr ? bus.in_wr_valid : valid_q;
      valid_wr_d = bus.in_wr_valid_wr;
      cout_d     = bus.cin_wr_data_wr ? bus.cin_wr_data : cout_q;
      cout_wr_d  = bus.cin_wr_data_wr;
      start_d    = bus.in_wr_data_wr && (data_hdr_c == HDR_HEAD) && !bypass_d;
      finish_d   = bus.in_wr_data_wr && (data_hdr_c == HDR_TAIL) && !bypass_d;
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         match_q     <= 1'b0;
         lat_addr_q  <= '0;
         hi16_q      <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         bypass_q    <= 1'b1;
         phv_q       <= '0;
         phv_wr_q    <= 1'b0;
         data_q      <= '0;
         data_wr_q   <= 1'b0;
         valid_q     <= 1'b0;
         valid_wr_q  <= 1'b0;
         cout_q      <= '0;
         cout_wr_q   <= 1'b0;
         start_q     <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         match_q     <= match_d;
         lat_addr_q  <= lat_addr_d;
         hi16_q      <= hi16_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         bypass_q    <= bypass_d;
         phv_q       <= phv_d;
         phv_wr_q    <= phv_wr_d;
         data_q      <= data_d;
         data_wr_q   <= data_wr_d;
         valid_q     <= valid_d;
         valid_wr_q  <= valid_wr_d;
         cout_q      <= cout_d;
         cout_wr_q   <= cout_wr_d;
         start_q     <= start_d;
         finish_q    <= finish_d;
      end
   end

   assign bus.out_wr_phv           = phv_q;
   assign bus.out_wr_phv_wr        = phv_wr_q;
   assign bus.out_wr_data          = data_q;
   assign bus.out_wr_data_wr       = data_wr_q;
   assign bus.out_wr_valid         = valid_q;
   assign bus.out_wr_valid_wr      = valid_wr_q;
   assign bus.cout_wr_data         = cout_q;
   assign bus.cout_wr_data_wr      = cout_wr_q;
   assign bus.wr2ram_wr_en         = ram_we_q;
   assign bus.wr2ram_addr          = ram_addr_q;
   assign bus.wr2ram_wdata         = ram_wdata_q;
   assign bus.pgm_bypass_flag      = bypass_q;
   assign bus.pgm_sent_start_flag  = start_q;
   assign bus.pgm_sent_finish_flag = finish_q;
endmodule

// File: tb/tb_pgm_wr_ctl.sv
// Bench for pgm_wr_ctl: directed scenarios then random traffic against a packet-level reference model.
module tb_pgm_wr_ctl;
   localparam logic [5:0] H_HEAD = 6'b010000;
   localparam logic [5:0] H_BODY = 6'b110000;
   localparam logic [5:0] H_TAIL = 6'b100000;

   logic clk;
   logic rst;
   pgm_wr_ctl_if bus ();

   pgm_wr_ctl dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // reference model: loaded-program flag and the cfg packet currently open
   logic         m_bypass, m_in_pkt, m_match;
   logic [6:0]   m_addr;
   logic [15:0]  m_hi16;
   // expected registered outputs
   logic [1023:0] e_phv;
   logic          e_phv_wr;
   logic [133:0]  e_data;
   logic          e_data_wr, e_valid, e_valid_wr;
   logic [133:0]  e_cout;
   logic          e_cout_wr, e_we, e_start, e_finish;
   logic [6:0]    e_waddr;
   logic [143:0]  e_wdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [133:0] cfg_head(input logic [7:0] id, input logic v, input logic [2:0] op,
                                             input logic [31:0] addr, input logic [15:0] hi);
      return {H_HEAD, v, op, 12'h0, id, 8'd62, addr, 32'hffffffff, 16'h0, hi};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [1023:0] rand_phv();
      logic [1023:0] v;
      for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Advance the model by one clock using the inputs presented for this edge
   task automatic model_step();
      logic [5:0] h;
      if (rst) begin
         m_bypass = 1'b1; m_in_pkt = 1'b0; m_match = 1'b0; m_addr = '0; m_hi16 = '0;
         e_phv = '0; e_phv_wr = 1'b0; e_data = '0; e_data_wr = 1'b0; e_valid = 1'b0; e_valid_wr = 1'b0;
         e_cout = '0; e_cout_wr = 1'b0; e_we = 1'b0; e_waddr = '0; e_wdata = '0;
         e_start = 1'b0; e_finish = 1'b0;
      end else begin
         e_phv_wr = bus.in_wr_phv_wr;
         if (bus.in_wr_phv_wr) e_phv = bus.in_wr_phv;
         e_data_wr = bus.in_wr_data_wr;
         if (bus.in_wr_data_wr) e_data = bus.in_wr_data;
         e_valid_wr = bus.in_wr_valid_wr;
         if (bus.in_wr_valid_wr) e_valid = bus.in_wr_valid;
         e_cout_wr = bus.cin_wr_data_wr;
         if (bus.cin_wr_data_wr) e_cout = bus.cin_wr_data;
         e_we = 1'b0;
         if (bus.cin_wr_data_wr) begin
            h = bus.cin_wr_data[133:128];
            if (h == H_HEAD) begin
               m_in_pkt = 1'b1;
               m_match  = bus.cin_wr_data[127] && bus.cin_wr_data[126:124] == 3'b001 &&
                          bus.cin_wr_data[111:104] == 8'd70;
               if (m_match) begin
                  m_addr = bus.cin_wr_data[70:64];
                  m_hi16 = bus.cin_wr_data[15:0];
               end
            end else if (h == H_TAIL && m_in_pkt) begin
               m_in_pkt = 1'b0;
               if (m_match) begin
                  e_we     = 1'b1;
                  e_waddr  = m_addr;
                  e_wdata  = {m_hi16, bus.cin_wr_data[127:0]};
                  m_bypass = 1'b0;
               end
               m_match = 1'b0;
            end
         end
         e_start  = bus.in_wr_data_wr && bus.in_wr_data[133:128] == H_HEAD && !m_bypass;
         e_finish = bus.in_wr_data_wr && bus.in_wr_data[133:128] == H_TAIL && !m_bypass;
      end
   endtask

   task automatic check_all();
      check("out_wr_phv", bus.out_wr_phv, e_phv);
      check("out_wr_phv_wr", bus.out_wr_phv_wr, e_phv_wr);
      check("out_wr_data", bus.out_wr_data, e_data);
      check("out_wr_data_wr", bus.out_wr_data_wr, e_data_wr);
      check("out_wr_valid", bus.out_wr_valid, e_valid);
      check("out_wr_valid_wr", bus.out_wr_valid_wr, e_valid_wr);
      check("cout_wr_data", bus.cout_wr_data, e_cout);
      check("cout_wr_data_wr", bus.cout_wr_data_wr, e_cout_wr);
      check("wr2ram_wr_en", bus.wr2ram_wr_en, e_we);
      check("wr2ram_addr", bus.wr2ram_addr, e_waddr);
      check("wr2ram_wdata", bus.wr2ram_wdata, e_wdata);
      check("pgm_bypass_flag", bus.pgm_bypass_flag, m_bypass);
      check("pgm_sent_start_flag", bus.pgm_sent_start_flag, e_start);
      check("pgm_sent_finish_flag", bus.pgm_sent_finish_flag, e_finish);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_data(input logic [5:0] h, input logic wr);
      bus.in_wr_data    = {h, rand128()};
      bus.in_wr_data_wr = wr;
   endtask

   task automatic rand_inputs();
      logic [31:0] r;
      logic [5:0]  h;
      logic [7:0]  id;
      r = $urandom;
      bus.in_wr_phv      = rand_phv();
      bus.in_wr_phv_wr   = r[0];
      bus.in_wr_valid    = r[1];
      bus.in_wr_valid_wr = r[2];
      case (r[4:3])
         2'd0:    h = H_HEAD;
         2'd1:    h = H_BODY;
         2'd2:    h = H_TAIL;
         default: h = 6'($urandom);
      endcase
      set_data(h, r[5]);
      bus.cin_wr_data_wr = 1'b1;
      case (r[8:6])
         3'd0, 3'd1: bus.cin_wr_data = cfg_head(8'd70, 1'b1, 3'b001, $urandom, 16'($urandom));
         3'd2: begin
            id = 8'($urandom);
            if (id == 8'd70) id = 8'd71;
            case (r[10:9])
               2'd0:    bus.cin_wr_data = cfg_head(id, 1'b1, 3'b001, $urandom, 16'($urandom));
               2'd1:    bus.cin_wr_data = cfg_head(8'd70, 1'b0, 3'b001, $urandom, 16'($urandom));
               default: bus.cin_wr_data = cfg_head(8'd70, 1'b1, 3'b010, $urandom, 16'($urandom));
            endcase
         end
         3'd3, 3'd4: bus.cin_wr_data = {H_TAIL, rand128()};
         3'd5:       bus.cin_wr_data = {H_BODY, rand128()};
         default: begin
            bus.cin_wr_data    = {H_TAIL, rand128()};
            bus.cin_wr_data_wr = 1'b0;
         end
      endcase
      rst = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      logic [133:0] tail;
      logic [2:0]   r3;
      rst = 1'b1;
      bus.in_wr_phv = '0;  bus.in_wr_phv_wr = 1'b0;
      bus.in_wr_data = '0; bus.in_wr_data_wr = 1'b0;
      bus.in_wr_valid = 1'b0; bus.in_wr_valid_wr = 1'b0;
      bus.in_wr_phv_alf = 1'b0; bus.in_wr_alf = 1'b0;
      bus.cin_wr_data = '0; bus.cin_wr_data_wr = 1'b0; bus.cin_wr_ready = 1'b0;

      // T1 reset
      tick();
      check("t1_bypass", bus.pgm_bypass_flag, 1'b1);
      check("t1_we", bus.wr2ram_wr_en, 1'b0);
      rst = 1'b0;

      // T4 data before any program: echoed, no start/finish
      set_data(H_HEAD, 1'b1); tick();
      check("t4_start", bus.pgm_sent_start_flag, 1'b0);
      set_data(H_BODY, 1'b1); tick();
      set_data(H_TAIL, 1'b1); tick();
      check("t4_finish", bus.pgm_sent_finish_flag, 1'b0);
      set_data(H_BODY, 1'b0); tick();

      // T3 non-matching ID: forwarded, no RAM write
      bus.cin_wr_data = cfg_head(8'd71, 1'b1, 3'b001, 32'h00010001, 16'h0);
      bus.cin_wr_data_wr = 1'b1; tick();
      bus.cin_wr_data = {H_TAIL, 32'h0, 32'h00010002, 64'h1122334455667788}; tick();
      check("t3_we", bus.wr2ram_wr_en, 1'b0);
      bus.cin_wr_data_wr = 1'b0; tick();
      check("t3_bypass", bus.pgm_bypass_flag, 1'b1);

      // T2 matching write
      bus.cin_wr_data = cfg_head(8'd70, 1'b1, 3'b001, 32'h00010001, 16'h0);
      bus.cin_wr_data_wr = 1'b1; tick();
      tail = {H_TAIL, 32'hdeadbeef, 32'h00010002, 64'h0123456789abcdef};
      bus.cin_wr_data = tail; tick();
      check("t2_we", bus.wr2ram_wr_en, 1'b1);
      check("t2_addr", bus.wr2ram_addr, 7'h01);
      check("t2_wdata", bus.wr2ram_wdata, {16'h0000, tail[127:0]});
      check("t2_bypass", bus.pgm_bypass_flag, 1'b0);
      bus.cin_wr_data_wr = 1'b0; tick();
      check("t2_we_pulse", bus.wr2ram_wr_en, 1'b0);

      // T5 data after program load
      set_data(H_HEAD, 1'b1); tick();
      check("t5_start", bus.pgm_sent_start_flag, 1'b1);
      set_data(H_TAIL, 1'b1); tick();
      check("t5_finish", bus.pgm_sent_finish_flag, 1'b1);
      set_data(H_BODY, 1'b0);
      bus.in_wr_phv = {128{8'hA5}}; bus.in_wr_phv_wr = 1'b1; tick();
      check("t5_phv", bus.out_wr_phv, {128{8'hA5}});
      bus.in_wr_phv_wr = 1'b0; tick();

      // T6 combinational pass-through
      for (int i = 0; i < 8; i++) begin
         r3 = 3'(i);
         bus.cin_wr_ready = r3[0]; bus.in_wr_alf = r3[1]; bus.in_wr_phv_alf = r3[2];
         #1;
         check("t6_cout_wr_ready", bus.cout_wr_ready, r3[0]);
         check("t6_out_wr_alf", bus.out_wr_alf, r3[1]);
         check("t6_out_wr_phv_alf", bus.out_wr_phv_alf, r3[2]);
      end

      // random traffic, including occasional mid-packet resets
      for (int n = 0; n < 600; n++) begin
         rand_inputs();
         r3 = 3'($urandom);
         bus.cin_wr_ready = r3[0]; bus.in_wr_alf = r3[1]; bus.in_wr_phv_alf = r3[2];
         #1;
         check("rnd_cout_wr_ready", bus.cout_wr_ready, r3[0]);
         check("rnd_out_wr_alf", bus.out_wr_alf, r3[1]);
         check("rnd_out_wr_phv_alf", bus.out_wr_phv_alf, r3[2]);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
